// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills
// the IF/ID register. Handles stall, branch/jump redirect with flush, and
// stops fetching once a HALT instruction has been latched.
// Optional macro IF_FETCH_COUNT_EN adds a saturating fetched-instruction
// counter on fetch_count; without it fetch_count is tied to zero.
module if_fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [4:0]  HALT_OP   = 5'b00001,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  output logic [7:0]  im_addr,
  input  logic [15:0] im_data,
  output logic [15:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic       is_halt_word;
  logic       fetch_fire;

  // Memory answers in the same cycle, so the address is simply the PC.
  assign im_addr      = pc;
  assign is_halt_word = (im_data[15:11] == HALT_OP);
  // An edge that loads a real instruction into ir.
  assign fetch_fire   = enable && (state == ST_RUN) && !br_taken && !stall;

  // Fetch state machine: PC, IF/ID register and the halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      ir       <= NOP_INSTR;
      ir_pc    <= 8'h00;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (br_taken) begin
            pc       <= br_target;
            ir       <= NOP_INSTR;
            ir_valid <= 1'b0;
          end else if (fetch_fire) begin
            ir       <= im_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (is_halt_word) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + 8'd1;
            end
          end
        end
        ST_HALT: begin
          if (br_taken) begin
            state    <= ST_RUN;
            halted   <= 1'b0;
            pc       <= br_target;
            ir       <= NOP_INSTR;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir       <= NOP_INSTR;
            ir_valid <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [15:0] fetch_count_q;

  // Count every real instruction load, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 16'h0000;
    end else if (fetch_fire && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage; the initiator side of the instruction-memory read interface.
- Owns the 8-bit PC and drives im_addr. Samples the 16-bit im_data returned combinationally in the same cycle.
- Registers the instruction and its PC into an IF/ID register for decode.
- Handles pipeline stall, branch/jump redirect with flush, and stops fetching after a HALT instruction.

Parameters:
- RESET_PC, 8'h00, PC value after reset and in IDLE.
- HALT_OP, 5'b00001, opcode field im_data[15:11] that identifies HALT.
- NOP_INSTR, 16'h0000, bubble value loaded into ir on flush or halt drain.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global run enable; 0 freezes every register.
- start  in  1  one-cycle pulse; starts fetching from IDLE.
- stall  in  1  hold request from decode/hazard unit.
- br_taken  in  1  redirect request from execute; covers jump, JMPR and taken branch.
- br_target  in  8  redirect destination PC.
- im_addr  out  8  instruction memory address, equal to pc (combinational).
- im_data  in  16  instruction memory read data, valid in the same cycle.
- ir  out  16  registered instruction to decode.
- ir_pc  out  8  PC of the instruction held in ir.
- ir_valid  out  1  ir holds a real fetched instruction, not a bubble.
- halted  out  1  high while in HALT state.
- fetch_count  out  16  fetched-instruction counter; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=NOP_INSTR, ir_pc=0, ir_valid=0, halted=0, fetch_count=0. Reset asserted mid-run aborts immediately; there is no drain.
- im_addr = pc at all times. No wait states; im_data is sampled at the same clock edge.
- enable=0: all registers hold, in every state. start, stall and br_taken are ignored.
- States and transitions (enable=1):
  - IDLE: pc held, ir_valid=0. start=1 moves to RUN on the next edge, with no fetch on that edge. br_taken ignored.
  - RUN, priority br_taken > stall > normal fetch:
    - br_taken=1: pc<=br_target, ir<=NOP_INSTR, ir_valid<=0. Overrides a simultaneous stall and a HALT currently on im_data.
    - stall=1: pc, ir, ir_pc, ir_valid all hold.
    - Normal fetch: ir<=im_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1. The increment is 8-bit modulo: 8'hFF wraps to 8'h00.
    - Normal fetch where im_data[15:11]==HALT_OP: the HALT is latched into ir (ir_valid=1), pc is NOT incremented, next state is HALT.
  - HALT: halted=1, pc holds.
    - First non-stalled cycle: ir<=NOP_INSTR, ir_valid<=0, so HALT is presented to decode exactly once. stall=1 holds ir.
    - br_taken=1: returns to RUN with pc<=br_target and ir flushed. This covers a HALT fetched behind an unresolved branch.
    - start is ignored. Only reset or br_taken leaves HALT.
- Latency: address presented in cycle N appears in ir after edge N+1. Redirect gives a one-bubble penalty; the first target instruction appears in ir two edges after br_taken.
- start while in RUN or HALT has no effect.

Optional Feature:
- Macro IF_FETCH_COUNT_EN.
- Defined: fetch_count increments by 1, saturating at 16'hFFFF, on every edge that loads ir with ir_valid<=1. Bubbles, stalls and IDLE cycles do not count. Cleared only by reset.
- Undefined: no counter register exists and fetch_count is tied to 16'h0000.

Test Plan:
- Reset, start pulse, memory holds a linear program at 0..3 with no HALT → ir_pc sequence 0,1,2,3; ir equals memory words; ir_valid=1 from the 2nd edge after start.
- stall=1 for 3 cycles while ir_pc=2 → ir, ir_pc=2 and pc=3 unchanged for 3 cycles; fetch resumes at 3; fetch_count (macro on) skips those cycles.
- br_taken=1, br_target=8'h4F asserted together with stall=1 at pc=8'h4E → next ir=NOP_INSTR with ir_valid=0; following ir_pc=8'h4F.
- pc=8'hFF with a non-HALT word → next pc=8'h00, ir_pc=8'hFF.
- HALT word at address 8'h69 → ir holds HALT for 1 cycle with ir_valid=1, then NOP with ir_valid=0; halted=1; pc stays 8'h69; start pulse has no effect; br_taken to 8'h10 resumes fetch from 8'h10.
- rst_n low mid-run at pc=8'h30 → outputs take reset values immediately, without a clock edge; state IDLE; no fetch until next start.
